// File: rtl/req_capture_prio_enc.sv
// Request-capture stage: latches request pulses into a pending register and
// presents the highest-priority unmasked pending index over valid/ready.
module req_capture_prio_enc #(
    parameter int N         = 8,
    parameter int IDX_W     = 3,
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_in,
    input  logic [N-1:0]     mask,
    input  logic             out_ready,
    input  logic             clr_overflow,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    output logic [N-1:0]     pending,
    output logic             overflow
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     req_q;
    logic [N-1:0]     set_vec;
    logic [N-1:0]     clr_vec;
    logic [N-1:0]     cand;
    logic [N-1:0]     pending_d;
    logic [IDX_W-1:0] sel_idx;
    logic             cand_any;
    logic             accept;
    logic             ovf_event;

    always_comb begin
        set_vec   = EDGE_MODE ? (req_in & ~req_q) : req_in;
        cand      = pending & ~mask;
        cand_any  = |cand;
        accept    = (state_q == HOLD) && out_ready;
        clr_vec   = accept ? (N'(1) << out_idx) : '0;
        // Set is OR-ed in after the clear, so a same-cycle arrival survives.
        pending_d = (pending & ~clr_vec) | set_vec;
        ovf_event = |(set_vec & pending & ~clr_vec);
    end

    // MSB-first: later iterations overwrite, so the highest set index wins.
    always_comb begin
        // NOTE: default assigned first so no path leaves sel_idx unassigned (no latch).
        sel_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cand_any) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending   <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_in;
            pending   <= pending_d;
            overflow  <= ovf_event | (overflow & ~clr_overflow);
            out_valid <= (state_d == HOLD);
            // Index is only loaded on entry to HOLD; it stays frozen while presented.
            if (state_q == IDLE && cand_any) out_idx <= sel_idx;
        end
    end

endmodule

// File: tb/tb_req_capture_prio_enc.sv
// Scoreboard bench for req_capture_prio_enc: stimulus pushes expected indices,
// a negedge monitor pops and compares them on every accepted handshake.
module tb_req_capture_prio_enc;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_in;
    logic [N-1:0]     mask;
    logic             out_ready;
    logic             clr_overflow;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic [N-1:0]     pending;
    logic             overflow;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic prev_accept = 1'b0;

    req_capture_prio_enc #(.N(N), .IDX_W(IDX_W), .EDGE_MODE(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .mask         (mask),
        .out_ready    (out_ready),
        .clr_overflow (clr_overflow),
        .out_idx      (out_idx),
        .out_valid    (out_valid),
        .pending      (pending),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted handshake must match the head of the queue,
    // and out_valid must be low on the cycle following an accept.
    always @(negedge clk) begin
        if (rst) begin
            prev_accept <= 1'b0;
        end else begin
            if (prev_accept) check("gap_after_accept", 32'(out_valid), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_accept", 32'(out_idx), 32'hFFFF_FFFF);
                end else begin
                    check("sb_idx", 32'(out_idx), 32'(exp_q.pop_front()));
                end
            end
            prev_accept <= out_valid && out_ready;
        end
    end

    initial begin
        rst = 1'b1; req_in = '0; mask = '0; out_ready = 1'b0; clr_overflow = 1'b0;
        tick();
        tick();
        check("rst_pending",   32'(pending),   32'h00);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        rst = 1'b0;

        // Single pulse on bit 2: pending, then presented, then cleared.
        out_ready = 1'b1;
        req_in = 8'b0000_0100;
        exp_q.push_back(2);
        tick();
        req_in = '0;
        check("s1_pending",   32'(pending),   32'h04);
        check("s1_valid_lo",  32'(out_valid), 32'd0);
        tick();
        check("s1_valid",     32'(out_valid), 32'd1);
        check("s1_idx",       32'(out_idx),   32'd2);
        tick();
        check("s1_cleared",   32'(pending),   32'h00);
        check("s1_valid_end", 32'(out_valid), 32'd0);

        // Three bits in one pulse: served 7, 4, 1 with gaps.
        req_in = 8'b1001_0010;
        exp_q.push_back(7); exp_q.push_back(4); exp_q.push_back(1);
        tick();
        req_in = '0;
        check("s2_pending", 32'(pending), 32'h92);
        for (int i = 0; i < 12; i++) begin
            if (pending == '0 && !out_valid) break;
            tick();
        end
        check("s2_drained", 32'(pending), 32'h00);
        check("s2_valid",   32'(out_valid), 32'd0);

        // Masked MSB waits until unmasked.
        mask = 8'h80;
        req_in = 8'h81;
        exp_q.push_back(0);
        tick();
        req_in = '0;
        tick();
        check("s3_idx0", 32'(out_idx), 32'd0);
        tick();
        check("s3_left",  32'(pending),   32'h80);
        check("s3_idle",  32'(out_valid), 32'd0);
        tick();
        check("s3_masked_idle", 32'(out_valid), 32'd0);
        mask = '0;
        exp_q.push_back(7);
        tick();
        check("s3_valid7", 32'(out_valid), 32'd1);
        check("s3_idx7",   32'(out_idx),   32'd7);
        tick();
        check("s3_cleared", 32'(pending), 32'h00);

        // Held transaction, repeated pulse raises overflow.
        out_ready = 1'b0;
        req_in = 8'h08;
        tick();
        req_in = '0;
        tick();
        check("s4_valid", 32'(out_valid), 32'd1);
        check("s4_idx",   32'(out_idx),   32'd3);
        tick();
        req_in = 8'h08;
        tick();
        req_in = '0;
        mask = 8'h08;
        check("s4_overflow", 32'(overflow), 32'd1);
        check("s4_pending",  32'(pending),  32'h08);
        tick();
        check("s4_masked_held", 32'(out_valid), 32'd1);
        check("s4_idx_stable",  32'(out_idx),   32'd3);
        check("s4_ovf_sticky",  32'(overflow),  32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("s4_ovf_clr", 32'(overflow), 32'd0);
        exp_q.push_back(3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        mask = '0;
        check("s4_cleared", 32'(pending), 32'h00);

        // Accept coincides with a new edge on the same bit: set wins.
        req_in = 8'h20;
        tick();
        req_in = '0;
        tick();
        check("s5_idx", 32'(out_idx), 32'd5);
        exp_q.push_back(5);
        exp_q.push_back(5);
        out_ready = 1'b1;
        req_in = 8'h20;
        tick();
        req_in = '0;
        out_ready = 1'b0;
        check("s5_pending_kept", 32'(pending),   32'h20);
        check("s5_no_overflow",  32'(overflow),  32'd0);
        check("s5_valid_lo",     32'(out_valid), 32'd0);
        tick();
        check("s5_represent", 32'(out_valid), 32'd1);
        check("s5_idx_again", 32'(out_idx),   32'd5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("s5_cleared", 32'(pending), 32'h00);

        // Reset in HOLD drops the transaction; a line held through reset
        // is captured exactly once afterwards.
        req_in = 8'hFF;
        tick();
        req_in = '0;
        tick();
        check("s6_hold",    32'(out_valid), 32'd1);
        check("s6_pending", 32'(pending),   32'hFF);
        rst = 1'b1;
        req_in = 8'h01;
        tick();
        check("s6_rst_pending",  32'(pending),   32'h00);
        check("s6_rst_valid",    32'(out_valid), 32'd0);
        check("s6_rst_idx",      32'(out_idx),   32'd0);
        check("s6_rst_overflow", 32'(overflow),  32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(0);
        tick();
        check("s6_capture", 32'(pending), 32'h01);
        tick();
        check("s6_idx0", 32'(out_idx), 32'd0);
        tick();
        tick();
        check("s6_once",     32'(pending),   32'h00);
        check("s6_no_again", 32'(out_valid), 32'd0);
        req_in = '0;
        out_ready = 1'b0;
        tick();
        tick();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
